// File: rtl/spi_control_seq.sv
// spi_control_seq: SPI word sequencer with TX/RX FIFOs, chip-select framing,
// sticky status flags and a registered interrupt.
module spi_control_seq #(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_CS = 2,
  localparam int CS_W = $clog2(NUM_CS),
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic              WR_EN,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              RD_EN,
  output logic [DATA_W-1:0] RD_DATA,
  input  logic [7:0]        CONTROL,
  input  logic [CS_W-1:0]   CS_SEL,
  input  logic              CLR_FLAGS,
  output logic              SH_START,
  output logic [DATA_W-1:0] SH_TXD,
  input  logic              SH_DONE,
  input  logic [DATA_W-1:0] SH_RXD,
  input  logic              ERR_IN,
  output logic [NUM_CS-1:0] CS_N,
  output logic [7:0]        STATUS,
  output logic              IRQ
);
  typedef enum logic [2:0] {IDLE, SETUP, XFER, WAIT, RELEASE} state_t;
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CS_W:0] NCS = (CS_W+1)'(NUM_CS);

  state_t state_q, state_d;
  logic [DATA_W-1:0] tx_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [AW:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic ovr_q, ovr_d, ovf_q, ovf_d, err_q, err_d, irq_q, irq_d, sh_start_q, sh_start_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic [DATA_W-1:0] sh_txd_q, sh_txd_d;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, rx_try, rx_push, rx_pop, go, cs_bad, stop_cur, stop_nxt, more;
  logic unused_ctrl;

  assign tx_empty = tx_cnt_q == '0;
  assign tx_full = tx_cnt_q == FULL;
  assign rx_empty = rx_cnt_q == '0;
  assign rx_full = rx_cnt_q == FULL;
  assign unused_ctrl = CONTROL[7];

  always_comb begin
    tx_push = WR_EN & ~tx_full;
    tx_pop = state_q == XFER;
    rx_pop = RD_EN & ~rx_empty;
    rx_try = (state_q == WAIT) & SH_DONE & CONTROL[6];
    rx_push = rx_try & ~rx_full;
    cs_bad = {1'b0, CS_SEL} >= NCS;
    stop_cur = ~CONTROL[2] | (CONTROL[0] & ovr_q) | (CONTROL[1] & ovf_q) | (CONTROL[5] & err_q);
    go = (state_q == IDLE) & ~tx_empty & ~stop_cur;
    ovr_d = (rx_try & rx_full) | (ovr_q & ~CLR_FLAGS);
    ovf_d = (WR_EN & tx_full) | (ovf_q & ~CLR_FLAGS);
    err_d = ERR_IN | (go & cs_bad) | (err_q & ~CLR_FLAGS);
    // burst continuation must see flags raised by this very word
    stop_nxt = ~CONTROL[2] | (CONTROL[0] & ovr_d) | (CONTROL[1] & ovf_d) | (CONTROL[5] & err_d);
    more = CONTROL[3] & ~tx_empty & ~stop_nxt;
    tx_wp_d = tx_wp_q + AW'(tx_push);
    tx_rp_d = tx_rp_q + AW'(tx_pop);
    tx_cnt_d = tx_cnt_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    rx_wp_d = rx_wp_q + AW'(rx_push);
    rx_rp_d = rx_rp_q + AW'(rx_pop);
    rx_cnt_d = rx_cnt_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    irq_d = CONTROL[4] & (~rx_empty | ovr_q | ovf_q | err_q);
    state_d = state_q;
    cs_n_d = cs_n_q;
    sh_start_d = 1'b0;
    case (state_q)
      IDLE: if (go & ~cs_bad) begin
        state_d = SETUP;
        cs_n_d = ~(NUM_CS'(1) << CS_SEL);
      end
      SETUP: begin
        state_d = XFER;
        sh_start_d = 1'b1;
      end
      XFER: state_d = WAIT;
      WAIT: if (SH_DONE) begin
        state_d = more ? XFER : RELEASE;
        sh_start_d = more;
        cs_n_d = more ? cs_n_q : '1;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    sh_txd_d = sh_start_d ? tx_mem_q[tx_rp_d] : sh_txd_q;
  end

  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= WR_DATA;
    if (rx_push) rx_mem_q[rx_wp_q] <= SH_RXD;
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= IDLE;
      tx_wp_q <= '0;
      tx_rp_q <= '0;
      tx_cnt_q <= '0;
      rx_wp_q <= '0;
      rx_rp_q <= '0;
      rx_cnt_q <= '0;
      ovr_q <= 1'b0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      irq_q <= 1'b0;
      sh_start_q <= 1'b0;
      sh_txd_q <= '0;
      cs_n_q <= '1;
    end else begin
      state_q <= state_d;
      tx_wp_q <= tx_wp_d;
      tx_rp_q <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q <= rx_wp_d;
      rx_rp_q <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      ovr_q <= ovr_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
      irq_q <= irq_d;
      sh_start_q <= sh_start_d;
      sh_txd_q <= sh_txd_d;
      cs_n_q <= cs_n_d;
    end
  end

  assign RD_DATA = rx_empty ? '0 : rx_mem_q[rx_rp_q];
  assign SH_START = sh_start_q;
  assign SH_TXD = sh_txd_q;
  assign CS_N = cs_n_q;
  assign IRQ = irq_q;
  assign STATUS = {err_q, state_q != IDLE, rx_full, rx_empty, ovf_q, ovr_q, tx_full, tx_empty};
endmodule

// File: tb/tb_spi_control_seq.sv
// tb_spi_control_seq: directed scenarios for spi_control_seq with hand-computed expectations.
module tb_spi_control_seq;
  logic CLK = 1'b0, CLR_N = 1'b1;
  logic WR_EN = 1'b0, RD_EN = 1'b0, CLR_FLAGS = 1'b0, SH_DONE = 1'b0, ERR_IN = 1'b0;
  logic [7:0] WR_DATA = '0, CONTROL = '0, SH_RXD = '0;
  logic CS_SEL = 1'b0;
  logic [7:0] RD_DATA, SH_TXD, STATUS;
  logic SH_START, IRQ;
  logic [1:0] CS_N;
  logic wr_en3 = 1'b0;
  logic [7:0] wr_data3 = '0, control3 = '0;
  logic [1:0] cs_sel3 = '0;
  logic [7:0] rd_data3, sh_txd3, status3;
  logic sh_start3, irq3;
  logic [2:0] cs_n3;
  int errors = 0, checks = 0;

  always #5 CLK = ~CLK;

  spi_control_seq #(.DATA_W(8), .FIFO_DEPTH(4), .NUM_CS(2)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .RD_EN(RD_EN),
    .RD_DATA(RD_DATA), .CONTROL(CONTROL), .CS_SEL(CS_SEL), .CLR_FLAGS(CLR_FLAGS),
    .SH_START(SH_START), .SH_TXD(SH_TXD), .SH_DONE(SH_DONE), .SH_RXD(SH_RXD),
    .ERR_IN(ERR_IN), .CS_N(CS_N), .STATUS(STATUS), .IRQ(IRQ)
  );

  spi_control_seq #(.DATA_W(8), .FIFO_DEPTH(4), .NUM_CS(3)) dut3 (
    .CLK(CLK), .CLR_N(CLR_N), .WR_EN(wr_en3), .WR_DATA(wr_data3), .RD_EN(1'b0),
    .RD_DATA(rd_data3), .CONTROL(control3), .CS_SEL(cs_sel3), .CLR_FLAGS(1'b0),
    .SH_START(sh_start3), .SH_TXD(sh_txd3), .SH_DONE(1'b0), .SH_RXD(8'h00),
    .ERR_IN(1'b0), .CS_N(cs_n3), .STATUS(status3), .IRQ(irq3)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    #3 CLR_N = 1'b0;
    #1;
    checks++; if (STATUS !== 8'h11) begin errors++; $display("FAIL reset_status got=%h exp=11", STATUS); end
    checks++; if (CS_N !== 2'b11) begin errors++; $display("FAIL reset_cs_n got=%b exp=11", CS_N); end
    checks++; if ({SH_START, SH_TXD, IRQ, RD_DATA} !== 18'h0) begin errors++; $display("FAIL reset_outputs got=%b/%h/%b/%h exp=0", SH_START, SH_TXD, IRQ, RD_DATA); end
    tick;
    CLR_N = 1'b1;
  endtask

  task automatic test_single;
    CONTROL = 8'h44; CS_SEL = 1'b1; WR_DATA = 8'hA5; WR_EN = 1'b1;
    tick;
    WR_EN = 1'b0;
    checks++; if (STATUS[0] !== 1'b0) begin errors++; $display("FAIL single_tx_not_empty got=%b exp=0", STATUS[0]); end
    tick;
    checks++; if (CS_N !== 2'b01 || SH_START !== 1'b0) begin errors++; $display("FAIL single_setup cs_n=%b start=%b exp=01/0", CS_N, SH_START); end
    tick;
    checks++; if (SH_START !== 1'b1 || SH_TXD !== 8'hA5) begin errors++; $display("FAIL single_xfer start=%b txd=%h exp=1/a5", SH_START, SH_TXD); end
    tick;
    checks++; if (SH_START !== 1'b0 || STATUS[0] !== 1'b1 || CS_N !== 2'b01) begin errors++; $display("FAIL single_wait start=%b txe=%b cs_n=%b exp=0/1/01", SH_START, STATUS[0], CS_N); end
    SH_DONE = 1'b1; SH_RXD = 8'h3C;
    tick;
    SH_DONE = 1'b0; SH_RXD = 8'h00;
    checks++; if (CS_N !== 2'b11 || RD_DATA !== 8'h3C || STATUS[4] !== 1'b0) begin errors++; $display("FAIL single_release cs_n=%b rd=%h rxe=%b exp=11/3c/0", CS_N, RD_DATA, STATUS[4]); end
    tick;
    checks++; if (STATUS[6] !== 1'b0) begin errors++; $display("FAIL single_idle busy=%b exp=0", STATUS[6]); end
    RD_EN = 1'b1;
    tick;
    checks++; if (STATUS[4] !== 1'b1 || RD_DATA !== 8'h00) begin errors++; $display("FAIL single_pop rxe=%b rd=%h exp=1/00", STATUS[4], RD_DATA); end
    tick;
    RD_EN = 1'b0;
    checks++; if (STATUS !== 8'h11) begin errors++; $display("FAIL pop_empty status=%h exp=11", STATUS); end
  endtask

  task automatic test_burst;
    CONTROL = 8'h4C; CS_SEL = 1'b0; WR_EN = 1'b1; WR_DATA = 8'h01;
    tick;
    WR_DATA = 8'h02;
    tick;
    WR_DATA = 8'h03;
    checks++; if (CS_N !== 2'b10) begin errors++; $display("FAIL burst_setup cs_n=%b exp=10", CS_N); end
    tick;
    WR_EN = 1'b0;
    checks++; if (SH_START !== 1'b1 || SH_TXD !== 8'h01) begin errors++; $display("FAIL burst_start0 start=%b txd=%h exp=1/01", SH_START, SH_TXD); end
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++; if (SH_START !== 1'b0 || CS_N !== 2'b10) begin errors++; $display("FAIL burst_wait%0d start=%b cs_n=%b exp=0/10", k, SH_START, CS_N); end
      SH_DONE = 1'b1; SH_RXD = 8'(8'h81 + k);
      tick;
      SH_DONE = 1'b0;
      if (k < 2) begin
        checks++; if (SH_START !== 1'b1 || SH_TXD !== 8'(k + 2) || CS_N !== 2'b10) begin errors++; $display("FAIL burst_start%0d start=%b txd=%h cs_n=%b exp=1/%h/10", k + 1, SH_START, SH_TXD, CS_N, 8'(k + 2)); end
      end else begin
        checks++; if (SH_START !== 1'b0 || CS_N !== 2'b11 || STATUS[6] !== 1'b1) begin errors++; $display("FAIL burst_release start=%b cs_n=%b busy=%b exp=0/11/1", SH_START, CS_N, STATUS[6]); end
      end
    end
    tick;
    checks++; if (STATUS[6] !== 1'b0 || CS_N !== 2'b11) begin errors++; $display("FAIL burst_idle busy=%b cs_n=%b exp=0/11", STATUS[6], CS_N); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (RD_DATA !== 8'(8'h81 + k)) begin errors++; $display("FAIL burst_rx%0d got=%h exp=%h", k, RD_DATA, 8'(8'h81 + k)); end
      RD_EN = 1'b1;
      tick;
      RD_EN = 1'b0;
    end
  endtask

  task automatic test_overflow;
    CONTROL = 8'h12;
    for (int k = 0; k < 5; k++) begin
      WR_DATA = 8'(8'h10 + k); WR_EN = 1'b1;
      tick;
    end
    WR_EN = 1'b0;
    checks++; if (STATUS[1] !== 1'b1 || STATUS[3] !== 1'b1 || IRQ !== 1'b0) begin errors++; $display("FAIL ovf_flags full=%b ovf=%b irq=%b exp=1/1/0", STATUS[1], STATUS[3], IRQ); end
    CONTROL = 8'h16;
    tick;
    checks++; if (IRQ !== 1'b1 || STATUS[6] !== 1'b0) begin errors++; $display("FAIL ovf_irq irq=%b busy=%b exp=1/0", IRQ, STATUS[6]); end
    CLR_FLAGS = 1'b1;
    tick;
    CLR_FLAGS = 1'b0;
    checks++; if (STATUS[3] !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", STATUS[3]); end
    CONTROL = 8'h44;
    for (int k = 0; k < 4; k++) begin
      tick;
      tick;
      checks++; if (SH_START !== 1'b1 || SH_TXD !== 8'(8'h10 + k)) begin errors++; $display("FAIL ovf_drain%0d start=%b txd=%h exp=1/%h", k, SH_START, SH_TXD, 8'(8'h10 + k)); end
      tick;
      SH_DONE = 1'b1; SH_RXD = 8'(8'hC0 + k);
      tick;
      SH_DONE = 1'b0;
      tick;
    end
    checks++; if (STATUS[0] !== 1'b1 || STATUS[5] !== 1'b1 || STATUS[6] !== 1'b0) begin errors++; $display("FAIL ovf_lost txe=%b rxf=%b busy=%b exp=1/1/0", STATUS[0], STATUS[5], STATUS[6]); end
  endtask

  task automatic test_overrun;
    CONTROL = 8'h45; WR_DATA = 8'h20; WR_EN = 1'b1;
    tick;
    WR_DATA = 8'h21;
    tick;
    WR_EN = 1'b0;
    tick;
    checks++; if (SH_START !== 1'b1 || SH_TXD !== 8'h20) begin errors++; $display("FAIL ovr_start start=%b txd=%h exp=1/20", SH_START, SH_TXD); end
    tick;
    SH_DONE = 1'b1; SH_RXD = 8'hDD;
    tick;
    SH_DONE = 1'b0;
    checks++; if (STATUS[2] !== 1'b1 || CS_N !== 2'b11) begin errors++; $display("FAIL ovr_flag ovr=%b cs_n=%b exp=1/11", STATUS[2], CS_N); end
    tick;
    tick;
    checks++; if (STATUS[6] !== 1'b0 || STATUS[0] !== 1'b0 || SH_START !== 1'b0) begin errors++; $display("FAIL ovr_stopped busy=%b txe=%b start=%b exp=0/0/0", STATUS[6], STATUS[0], SH_START); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (RD_DATA !== 8'(8'hC0 + k)) begin errors++; $display("FAIL ovr_rx%0d got=%h exp=%h", k, RD_DATA, 8'(8'hC0 + k)); end
      RD_EN = 1'b1;
      tick;
      RD_EN = 1'b0;
    end
    checks++; if (STATUS[4] !== 1'b1 || RD_DATA !== 8'h00) begin errors++; $display("FAIL ovr_dropped rxe=%b rd=%h exp=1/00", STATUS[4], RD_DATA); end
  endtask

  task automatic test_reset_wait;
    CLR_FLAGS = 1'b1; CONTROL = 8'h44;
    tick;
    CLR_FLAGS = 1'b0;
    checks++; if (STATUS[2] !== 1'b0 || CS_N !== 2'b10) begin errors++; $display("FAIL rstw_resume ovr=%b cs_n=%b exp=0/10", STATUS[2], CS_N); end
    tick;
    checks++; if (SH_START !== 1'b1 || SH_TXD !== 8'h21) begin errors++; $display("FAIL rstw_start start=%b txd=%h exp=1/21", SH_START, SH_TXD); end
    tick;
    checks++; if (STATUS[6] !== 1'b1 || CS_N !== 2'b10) begin errors++; $display("FAIL rstw_wait busy=%b cs_n=%b exp=1/10", STATUS[6], CS_N); end
    #1 CLR_N = 1'b0;
    #1;
    checks++; if (CS_N !== 2'b11 || STATUS !== 8'h11 || SH_START !== 1'b0 || SH_TXD !== 8'h00) begin errors++; $display("FAIL rstw_async cs_n=%b status=%h start=%b txd=%h exp=11/11/0/00", CS_N, STATUS, SH_START, SH_TXD); end
    tick;
    CLR_N = 1'b1; SH_DONE = 1'b1; SH_RXD = 8'hEE;
    tick;
    SH_DONE = 1'b0;
    checks++; if (STATUS !== 8'h11 || RD_DATA !== 8'h00 || CS_N !== 2'b11) begin errors++; $display("FAIL rstw_done_ignored status=%h rd=%h cs_n=%b exp=11/00/11", STATUS, RD_DATA, CS_N); end
  endtask

  task automatic test_flags;
    CONTROL = 8'h10; ERR_IN = 1'b1;
    tick;
    ERR_IN = 1'b0;
    checks++; if (STATUS[7] !== 1'b1 || IRQ !== 1'b0) begin errors++; $display("FAIL err_set err=%b irq=%b exp=1/0", STATUS[7], IRQ); end
    tick;
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL err_irq got=%b exp=1", IRQ); end
    ERR_IN = 1'b1; CLR_FLAGS = 1'b1;
    tick;
    ERR_IN = 1'b0;
    checks++; if (STATUS[7] !== 1'b1) begin errors++; $display("FAIL err_set_wins got=%b exp=1", STATUS[7]); end
    tick;
    CLR_FLAGS = 1'b0;
    checks++; if (STATUS !== 8'h11) begin errors++; $display("FAIL err_clear status=%h exp=11", STATUS); end
    tick;
    CONTROL = 8'h00;
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL err_irq_drop got=%b exp=0", IRQ); end
  endtask

  task automatic test_bad_cs;
    control3 = 8'h04; cs_sel3 = 2'd3; wr_data3 = 8'h5A; wr_en3 = 1'b1;
    tick;
    wr_en3 = 1'b0;
    tick;
    checks++; if (status3[7] !== 1'b1 || cs_n3 !== 3'b111 || status3[6] !== 1'b0) begin errors++; $display("FAIL badcs_err err=%b cs_n=%b busy=%b exp=1/111/0", status3[7], cs_n3, status3[6]); end
    tick;
    checks++; if (cs_n3 !== 3'b111 || status3[0] !== 1'b0 || sh_start3 !== 1'b0 || irq3 !== 1'b0 || rd_data3 !== 8'h00) begin errors++; $display("FAIL badcs_idle cs_n=%b txe=%b start=%b irq=%b rd=%h exp=111/0/0/0/00", cs_n3, status3[0], sh_start3, irq3, rd_data3); end
    cs_sel3 = 2'd2;
    tick;
    checks++; if (cs_n3 !== 3'b011) begin errors++; $display("FAIL cs2_setup got=%b exp=011", cs_n3); end
    tick;
    checks++; if (sh_start3 !== 1'b1 || sh_txd3 !== 8'h5A) begin errors++; $display("FAIL cs2_start start=%b txd=%h exp=1/5a", sh_start3, sh_txd3); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_burst;
    test_overflow;
    test_overrun;
    test_reset_wait;
    test_flags;
    test_bad_cs;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_control_seq.md
SPI_CONTROL_SEQ -- requirements
Module: spi_control_seq

Interface
REQ-001 Parameter DATA_W, default 8, is the SPI word width in bits (>=4).
REQ-002 Parameter FIFO_DEPTH, default 4, is the TX and RX FIFO depth in words (power of 2, >=2).
REQ-003 Parameter NUM_CS, default 2, is the chip-select count (>=2); CS_W = clog2(NUM_CS).
REQ-004 CLK  in  1  single clock; all state updates on the rising edge.
REQ-005 CLR_N  in  1  reset, asynchronous, active-low.
REQ-006 WR_EN / WR_DATA  in  1 / DATA_W  TX FIFO push strobe and word.
REQ-007 RD_EN  in  1  RX FIFO pop strobe; RD_DATA  out  DATA_W  RX head word, first-word fall-through, 0 when RX is empty.
REQ-008 CONTROL  in  8  control bits: [0] stop on RX overrun, [1] stop on TX overflow, [2] TE, [3] CS hold between words, [4] IRQ enable, [5] stop on error, [6] RE, [7] reserved.
REQ-009 CS_SEL  in  CS_W  target slave index; CLR_FLAGS  in  1  one-cycle pulse clearing the sticky flags.
REQ-010 SH_START  out  1  one-cycle start pulse to the shift engine; SH_TXD  out  DATA_W  word to send, valid while SH_START=1.
REQ-011 SH_DONE  in  1  one-cycle pulse, word complete; SH_RXD  in  DATA_W  received word, valid while SH_DONE=1; ERR_IN  in  1  link error.
REQ-012 CS_N  out  NUM_CS  active-low chip selects; STATUS  out  8  status; IRQ  out  1  registered interrupt.

Function
REQ-013 STATUS SHALL be [0] TX empty, [1] TX full, [2] RX overrun (sticky), [3] TX overflow (sticky), [4] RX empty, [5] RX full, [6] busy (FSM not IDLE), [7] error (sticky).
REQ-014 FIFOs SHALL use wrap-around pointers plus a clog2(FIFO_DEPTH)+1-bit occupancy count; full = count==FIFO_DEPTH.
REQ-015 WR_EN with TX full SHALL drop the word and set STATUS[3], even if a pop occurs in the same cycle; otherwise the word is pushed.
REQ-016 RD_EN with RX empty SHALL have no effect; simultaneous push and pop on non-full, non-empty RX SHALL keep the count unchanged.
REQ-017 stop = ~CONTROL[2] | (CONTROL[0]&STATUS[2]) | (CONTROL[1]&STATUS[3]) | (CONTROL[5]&STATUS[7]).
REQ-018 FSM states: IDLE, SETUP, XFER, WAIT, RELEASE.
REQ-019 IDLE->SETUP when TX is not empty and stop=0; CS_SEL is latched on this transition. If CS_SEL>=NUM_CS, SHALL instead set STATUS[7] and remain in IDLE.
REQ-020 SETUP: drive CS_N[latched]=0 for one cycle, then go to XFER.
REQ-021 XFER: for one cycle, SH_START=1, SH_TXD=TX head, and the TX FIFO pops; then go to WAIT.
REQ-022 WAIT: on SH_DONE, if CONTROL[6]=1, push SH_RXD to RX; if RX is full, drop the word and set STATUS[2]. SH_DONE in any other state is ignored.
REQ-023 WAIT exit on SH_DONE: go to XFER (CS held low) if CONTROL[3]=1, TX is not empty and stop=0 (evaluated with flags updated that cycle); otherwise go to RELEASE.
REQ-024 RELEASE: CS_N all high for one cycle, then go to IDLE; at most one CS_N bit is ever low.
REQ-025 Clearing TE mid-burst SHALL let the current word complete, then go through RELEASE.
REQ-026 ERR_IN=1 in any cycle sets STATUS[7]; CLR_FLAGS clears STATUS[2],[3],[7]; a set event in the same cycle as CLR_FLAGS SHALL win.
REQ-027 IRQ (registered, 1 cycle latency) = CONTROL[4] & (~RX empty | STATUS[2] | STATUS[3] | STATUS[7]).

Reset
REQ-028 On CLR_N low, SHALL immediately: empty both FIFOs with pointers 0, FSM=IDLE, CS_N all ones, SH_START=0, SH_TXD=0, IRQ=0, RD_DATA=0, STATUS=8'h11.
REQ-029 Reset mid-transfer SHALL abort with no RX push; a later SH_DONE is ignored.

Verification (DATA_W=8, FIFO_DEPTH=4, NUM_CS=2)
REQ-030 Single word: CONTROL=8'h44, CS_SEL=1, push 8'hA5 -> CS_N=2'b01 from SETUP; SH_START with SH_TXD=8'hA5 one cycle later; SH_DONE with SH_RXD=8'h3C -> RD_DATA=8'h3C, STATUS[4]=0; CS_N=2'b11 after RELEASE.
REQ-031 Burst: CONTROL=8'h4C, push 8'h01, 8'h02, 8'h03 -> three SH_START pulses; CS_N[0] stays low throughout; a single RELEASE after the third SH_DONE.
REQ-032 TX overflow: TE=0, push 5 words -> STATUS[1]=1, STATUS[3]=1, fifth word lost; with CONTROL=8'h16, IRQ rises one cycle later; CLR_FLAGS clears STATUS[3].
REQ-033 RX overrun: RE=1, no reads, 5 transfers -> fifth word dropped, STATUS[2]=1; with CONTROL[0]=1, FSM stops after the current word.
REQ-034 Reset in WAIT: CLR_N low -> CS_N=2'b11, STATUS=8'h11 immediately; SH_DONE after release is ignored.
REQ-035 CS_SEL=2 (requires NUM_CS=3, CS_W=2) with CS_SEL=3 -> STATUS[7]=1, no CS_N bit low, FSM stays IDLE.
